// File: rtl/note_tracker.sv
// note_tracker: maps FFT bins to notes, debounces per-note activity,
// reports lowest active note (class/octave) and full mask per frame.
// Ports: clk, reset (sync, high); bin_addr/bin_mag/bin_we/bin_last in;
// threshold/hysteresis levels; cfg_we/cfg_note/cfg_bin/cfg_en table;
// note/octave/note_valid/result_strobe/active_mask/busy/overrun out.
module note_tracker #(
  parameter int NUM_OCTAVES = 5,
  parameter int BIN_W       = 12,
  parameter int MAG_W       = 10,
  parameter int HOLD_FRAMES = 2,
  localparam int NOTES      = 12 * NUM_OCTAVES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BIN_W-1:0] bin_addr,
  input  logic [MAG_W-1:0] bin_mag,
  input  logic             bin_we,
  input  logic             bin_last,
  input  logic [MAG_W-1:0] threshold,
  input  logic [MAG_W-1:0] hysteresis,
  input  logic             cfg_we,
  input  logic [5:0]       cfg_note,
  input  logic [BIN_W-1:0] cfg_bin,
  input  logic             cfg_en,
  output logic [3:0]       note,
  output logic [2:0]       octave,
  output logic             note_valid,
  output logic             result_strobe,
  output logic [NOTES-1:0] active_mask,
  output logic             busy,
  output logic             overrun
);

  localparam logic [5:0] LAST_IDX = 6'(NOTES - 1);
  localparam logic [5:0] NOTES_6  = 6'(NOTES);
  localparam logic [3:0] HOLD     = 4'(HOLD_FRAMES);

  typedef enum logic [1:0] {
    COLLECT,
    SCAN,
    REPORT
  } state_t;

  state_t state, state_n;

  logic             tbl_en  [NOTES];
  logic [BIN_W-1:0] tbl_bin [NOTES];
  logic [MAG_W-1:0] peak    [NOTES];
  logic [3:0]       cnt     [NOTES];
  logic [NOTES-1:0] act, act_n;

  logic [5:0] idx;
  logic [3:0] pc, res_pc, hit_pc;
  logic [2:0] oc, res_oc, hit_oc;
  logic       found;

  logic [MAG_W-1:0] rel_lvl, cur_peak;
  logic [3:0]       cur_cnt, cnt_n;
  logic             act_bit;

  assign busy = (state == SCAN);

  always_ff @(posedge clk) begin
    if (reset) state <= COLLECT;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      COLLECT: if (bin_we && bin_last) state_n = SCAN;
      SCAN:    if (idx == LAST_IDX)    state_n = REPORT;
      REPORT:  state_n = COLLECT;
      default: state_n = COLLECT;
    endcase
  end

  // Evaluation of the note currently under the scan pointer.
  always_comb begin
    rel_lvl  = (threshold > hysteresis) ? threshold - hysteresis : '0;
    cur_peak = peak[idx];
    cur_cnt  = cnt[idx];
    cnt_n    = cur_cnt;
    act_bit  = act[idx];
    act_n    = act;
    if (cur_peak > threshold) begin
      cnt_n = (cur_cnt >= HOLD) ? HOLD : cur_cnt + 4'd1;
      if (cnt_n == HOLD) act_bit = 1'b1;
    end else if (!(act[idx] && cur_peak >= rel_lvl)) begin
      cnt_n   = 4'd0;
      act_bit = 1'b0;
    end
    act_n[idx] = act_bit;
    hit_pc = found ? res_pc : (act_bit ? pc : 4'd0);
    hit_oc = found ? res_oc : (act_bit ? oc : 3'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NOTES; i++) begin
        tbl_en[i]  <= 1'b0;
        tbl_bin[i] <= '0;
        peak[i]    <= '0;
        cnt[i]     <= '0;
      end
      act           <= '0;
      idx           <= '0;
      pc            <= 4'd1;
      oc            <= 3'd1;
      res_pc        <= '0;
      res_oc        <= '0;
      found         <= 1'b0;
      note          <= '0;
      octave        <= '0;
      note_valid    <= 1'b0;
      result_strobe <= 1'b0;
      active_mask   <= '0;
      overrun       <= 1'b0;
    end else begin
      result_strobe <= 1'b0;
      if (cfg_we && cfg_note < NOTES_6) begin
        tbl_en[cfg_note]  <= cfg_en;
        tbl_bin[cfg_note] <= cfg_bin;
      end
      if (bin_we && state != COLLECT) overrun <= 1'b1;
      unique case (state)
        COLLECT: begin
          if (bin_we) begin
            for (int i = 0; i < NOTES; i++) begin
              if (tbl_en[i] && tbl_bin[i] == bin_addr
                  && bin_mag > peak[i])
                peak[i] <= bin_mag;
            end
          end
          idx   <= '0;
          pc    <= 4'd1;
          oc    <= 3'd1;
          found <= 1'b0;
        end
        SCAN: begin
          peak[idx] <= '0;
          cnt[idx]  <= cnt_n;
          act       <= act_n;
          idx       <= idx + 6'd1;
          // Running class/octave counters avoid a divide by 12.
          if (pc == 4'd12) begin
            pc <= 4'd1;
            oc <= oc + 3'd1;
          end else begin
            pc <= pc + 4'd1;
          end
          if (!found && act_bit) begin
            found  <= 1'b1;
            res_pc <= pc;
            res_oc <= oc;
          end
          // Load outputs so they are visible during REPORT.
          if (idx == LAST_IDX) begin
            note          <= hit_pc;
            octave        <= hit_oc;
            note_valid    <= (hit_pc != 4'd0);
            active_mask   <= act_n;
            result_strobe <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_note_tracker.sv
// tb_note_tracker: scoreboard bench for note_tracker.
// Expected frame results are queued at bin_last and popped on strobe.
module tb_note_tracker;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] bin_addr;
  logic [9:0]  bin_mag;
  logic        bin_we, bin_last;
  logic [9:0]  threshold, hysteresis;
  logic        cfg_we;
  logic [5:0]  cfg_note;
  logic [11:0] cfg_bin;
  logic        cfg_en;
  logic [3:0]  note;
  logic [2:0]  octave;
  logic        note_valid, result_strobe;
  logic [59:0] active_mask;
  logic        busy, overrun;

  note_tracker dut (
    .clk(clk), .reset(reset),
    .bin_addr(bin_addr), .bin_mag(bin_mag),
    .bin_we(bin_we), .bin_last(bin_last),
    .threshold(threshold), .hysteresis(hysteresis),
    .cfg_we(cfg_we), .cfg_note(cfg_note),
    .cfg_bin(cfg_bin), .cfg_en(cfg_en),
    .note(note), .octave(octave),
    .note_valid(note_valid),
    .result_strobe(result_strobe),
    .active_mask(active_mask),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  n;
    logic [2:0]  o;
    logic [59:0] m;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  localparam logic [59:0] B2  = 60'd1 << 2;
  localparam logic [59:0] B4  = 60'd1 << 4;
  localparam logic [59:0] B5  = 60'd1 << 5;
  localparam logic [59:0] B9  = 60'd1 << 9;
  localparam logic [59:0] B21 = 60'd1 << 21;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (result_strobe === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("note", 64'(note), 64'(e.n));
        check("octave", 64'(octave), 64'(e.o));
        check("valid", 64'(note_valid), 64'(e.n != 4'd0));
        check("mask", 64'(active_mask), 64'(e.m));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic cfg(input logic [5:0] n, input logic [11:0] b,
                     input logic en);
    cfg_we = 1'b1; cfg_note = n; cfg_bin = b; cfg_en = en;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic send_bin(input logic [11:0] a, input logic [9:0] m,
                          input logic last);
    bin_we = 1'b1; bin_addr = a; bin_mag = m; bin_last = last;
    tick();
    bin_we = 1'b0; bin_last = 1'b0;
  endtask

  task automatic wait_strobe();
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (result_strobe === 1'b1) seen = 1'b1;
    end
    if (!seen) check("strobe_timeout", 64'd0, 64'd1);
    tick();
  endtask

  task automatic frame(input bit two,
                       input logic [11:0] a0, input logic [9:0] m0,
                       input logic [11:0] a1, input logic [9:0] m1,
                       input logic [3:0] en, input logic [2:0] eo,
                       input logic [59:0] em);
    if (two) send_bin(a0, m0, 1'b0);
    sb.push_back('{en, eo, em});
    send_bin(a1, m1, 1'b1);
    wait_strobe();
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, "_note"}, 64'(note), 64'd0);
    check({tag, "_oct"}, 64'(octave), 64'd0);
    check({tag, "_valid"}, 64'(note_valid), 64'd0);
    check({tag, "_strobe"}, 64'(result_strobe), 64'd0);
    check({tag, "_mask"}, 64'(active_mask), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_ovr"}, 64'(overrun), 64'd0);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    bin_we = 1'b0; bin_last = 1'b0; bin_addr = '0; bin_mag = '0;
    cfg_we = 1'b0; cfg_note = '0; cfg_bin = '0; cfg_en = 1'b0;
    threshold = 10'd50; hysteresis = 10'd10;
    do_reset();
    check_idle("rst");

    // Two-frame debounce on A1/A2.
    cfg(6'd9, 12'h012, 1'b1);
    cfg(6'd21, 12'h025, 1'b1);
    frame(1, 12'h012, 80, 12'h025, 90, 4'd0, 3'd0, '0);
    frame(1, 12'h012, 80, 12'h025, 90, 4'd10, 3'd1, B9 | B21);

    // Hysteresis hold (45, boundary 40) then release at 39.
    frame(1, 12'h012, 45, 12'h025, 40, 4'd10, 3'd1, B9 | B21);
    frame(1, 12'h012, 39, 12'h025, 90, 4'd10, 3'd2, B21);
    frame(0, 12'h000, 0, 12'h025, 39, 4'd0, 3'd0, '0);

    // Shared bin; mag equal to threshold does not count.
    do_reset();
    cfg(6'd4, 12'h00E, 1'b1);
    cfg(6'd5, 12'h00E, 1'b1);
    frame(0, 12'h000, 0, 12'h00E, 50, 4'd0, 3'd0, '0);
    frame(0, 12'h000, 0, 12'h00E, 60, 4'd0, 3'd0, '0);
    frame(0, 12'h000, 0, 12'h00E, 60, 4'd5, 3'd1, B4 | B5);
    hysteresis = 10'd60;
    frame(0, 12'h000, 0, 12'h07F, 0, 4'd5, 3'd1, B4 | B5);
    hysteresis = 10'd10;
    frame(0, 12'h000, 0, 12'h07F, 0, 4'd0, 3'd0, '0);

    // Out-of-range and disabled entries never match.
    do_reset();
    cfg(6'd62, 12'h040, 1'b1);
    cfg(6'd7, 12'h040, 1'b0);
    frame(0, 12'h000, 0, 12'h040, 1023, 4'd0, 3'd0, '0);
    frame(0, 12'h000, 0, 12'h040, 1023, 4'd0, 3'd0, '0);

    // Latency and overrun; dropped bin must not reach next frame.
    do_reset();
    cfg(6'd2, 12'h030, 1'b1);
    sb.push_back('{4'd0, 3'd0, 60'd0});
    send_bin(12'h030, 80, 1'b1);
    for (int k = 1; k <= 61; k++) begin
      if (k == 5) begin
        bin_we = 1'b1; bin_addr = 12'h030;
        bin_mag = 10'd1023; bin_last = 1'b0;
      end
      @(negedge clk);
      check($sformatf("busy_%0d", k), 64'(busy), 64'(k <= 60));
      check($sformatf("strb_%0d", k), 64'(result_strobe),
            64'(k == 61));
      tick();
      bin_we = 1'b0;
    end
    @(negedge clk);
    check("overrun_set", 64'(overrun), 64'd1);
    check("collect_idle", 64'(busy), 64'd0);
    tick();
    frame(0, 12'h000, 0, 12'h07F, 0, 4'd0, 3'd0, '0);
    @(negedge clk);
    check("overrun_sticky", 64'(overrun), 64'd1);
    tick();

    // Reset mid-scan abandons the frame and the debounce state.
    frame(0, 12'h000, 0, 12'h030, 80, 4'd0, 3'd0, '0);
    frame(0, 12'h000, 0, 12'h030, 80, 4'd3, 3'd1, B2);
    send_bin(12'h030, 80, 1'b1);
    repeat (29) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("midrst");
    repeat (70) @(negedge clk);
    tick();
    cfg(6'd2, 12'h030, 1'b1);
    frame(0, 12'h000, 0, 12'h030, 80, 4'd0, 3'd0, '0);
    frame(0, 12'h000, 0, 12'h030, 80, 4'd3, 3'd1, B2);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
